// File: rtl/fm_stream_reader.sv
// fm_stream_reader: streams pooled feature-map rows from fm_bram as 16-bit words.
// Define FM_PREFETCH_EN for a double-buffered, gap-free stream.
module fm_stream_reader #(
  parameter int ROWS   = 16,
  parameter int WORDS  = 25,
  parameter int RD_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fc_1_en,
  output logic          fm_bram_ena,
  output logic [4:0]    fm_bram_addra,
  input  logic [1119:0] fm_bram_douta,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [15:0]   out_data,
  output logic          out_row_last,
  output logic          out_last,
  output logic          fc_1_finish
);

  localparam int BW = WORDS * 16;
  localparam int XW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int CW = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] ISSUE  = 3'd1;
  localparam logic [2:0] WAIT   = 3'd2;
  localparam logic [2:0] STREAM = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  logic [2:0]    state;
  logic          en_q;
  logic          arm;
  logic          busy;
  logic [4:0]    row;
  logic [XW-1:0] widx;
  logic [CW-1:0] cnt;
  logic [BW-1:0] buf0;
  logic [BW-1:0] cur;
`ifdef FM_PREFETCH_EN
  logic [BW-1:0] buf1;
  logic          sel;
  logic          tgt;
`endif

  logic rise;
  logic accept;
  logic wlast;
  logic rlast;
  logic cap;
  logic abort;
  logic unused_bits;

  assign unused_bits = ^fm_bram_douta;

  // arm blocks a start until fc_1_en has been seen low after reset
  always_comb begin
    rise   = fc_1_en & ~en_q & arm;
    wlast  = (widx == XW'(WORDS - 1));
    rlast  = (row == 5'(ROWS - 1));
    cap    = busy && (cnt == '0);
    abort  = !fc_1_en &&
             (state == ISSUE || state == WAIT ||
              state == STREAM);
`ifdef FM_PREFETCH_EN
    cur    = sel ? buf1 : buf0;
`else
    cur    = buf0;
`endif
    out_valid    = (state == STREAM);
    accept       = out_valid & out_ready;
    out_data     = cur[{widx, 4'h0} +: 16];
    out_row_last = out_valid & wlast;
    out_last     = out_row_last & rlast;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      en_q          <= 1'b0;
      arm           <= 1'b0;
      busy          <= 1'b0;
      row           <= '0;
      widx          <= '0;
      cnt           <= '0;
      buf0          <= '0;
      fm_bram_ena   <= 1'b0;
      fm_bram_addra <= '0;
      fc_1_finish   <= 1'b0;
`ifdef FM_PREFETCH_EN
      buf1          <= '0;
      sel           <= 1'b0;
      tgt           <= 1'b0;
`endif
    end else begin
      en_q        <= fc_1_en;
      fm_bram_ena <= 1'b0;
      if (!fc_1_en) arm <= 1'b1;

      // read engine: cnt counts down from the issue cycle to capture
      if (busy) begin
        if (cnt == '0) begin
          busy <= 1'b0;
`ifdef FM_PREFETCH_EN
          if (tgt) buf1 <= fm_bram_douta[BW-1:0];
          else     buf0 <= fm_bram_douta[BW-1:0];
`else
          buf0 <= fm_bram_douta[BW-1:0];
`endif
        end else begin
          cnt <= cnt - 1'b1;
        end
      end

      if (abort) begin
        state <= IDLE;
        busy  <= 1'b0;
        row   <= '0;
        widx  <= '0;
      end else begin
        unique case (state)
          IDLE, DONE: begin
            if (rise) begin
              state         <= ISSUE;
              row           <= '0;
              widx          <= '0;
              fc_1_finish   <= 1'b0;
              fm_bram_ena   <= 1'b1;
              fm_bram_addra <= '0;
              busy          <= 1'b1;
              cnt           <= CW'(RD_LAT);
`ifdef FM_PREFETCH_EN
              sel           <= 1'b0;
              tgt           <= 1'b0;
`endif
            end
          end
          ISSUE: state <= WAIT;
          WAIT: begin
            if (cap) begin
              state <= STREAM;
              widx  <= '0;
`ifdef FM_PREFETCH_EN
              sel   <= tgt;
              if (!rlast) begin
                fm_bram_ena   <= 1'b1;
                fm_bram_addra <= row + 1'b1;
                busy          <= 1'b1;
                cnt           <= CW'(RD_LAT);
                tgt           <= ~tgt;
              end
`endif
            end
          end
          STREAM: begin
            if (accept) begin
              if (!wlast) begin
                widx <= widx + 1'b1;
              end else if (rlast) begin
                state       <= DONE;
                fc_1_finish <= 1'b1;
              end else begin
                row  <= row + 1'b1;
                widx <= '0;
`ifdef FM_PREFETCH_EN
                if (!busy || cap) begin
                  sel <= ~sel;
                  if (32'(row) + 2 < ROWS) begin
                    fm_bram_ena   <= 1'b1;
                    fm_bram_addra <= row + 5'd2;
                    busy          <= 1'b1;
                    cnt           <= CW'(RD_LAT);
                    tgt           <= sel;
                  end
                end else begin
                  state <= WAIT;
                end
`else
                state         <= ISSUE;
                fm_bram_ena   <= 1'b1;
                fm_bram_addra <= row + 1'b1;
                busy          <= 1'b1;
                cnt           <= CW'(RD_LAT);
`endif
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fm_stream_reader.sv
// tb_fm_stream_reader: directed checks of fm_stream_reader against a
// latency-2 BRAM model holding word i of row r = r*32+i.
module tb_fm_stream_reader;

`ifdef FM_PREFETCH_EN
  localparam int GAP = 0;
`else
  localparam int GAP = 3;
`endif
  localparam int LAST_CYC = 403 + 15 * GAP;

  logic          clk = 1'b0;
  logic          rst;
  logic          fc_1_en;
  logic          fm_bram_ena;
  logic [4:0]    fm_bram_addra;
  logic [1119:0] fm_bram_douta;
  logic          out_valid;
  logic          out_ready;
  logic [15:0]   out_data;
  logic          out_row_last;
  logic          out_last;
  logic          fc_1_finish;

  logic [1119:0] s1 = '0;
  logic [1119:0] s2 = '0;

  int checks = 0;
  int failures = 0;
  int lc;
  int nw;

  fm_stream_reader dut (
    .clk(clk),
    .rst(rst),
    .fc_1_en(fc_1_en),
    .fm_bram_ena(fm_bram_ena),
    .fm_bram_addra(fm_bram_addra),
    .fm_bram_douta(fm_bram_douta),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_row_last(out_row_last),
    .out_last(out_last),
    .fc_1_finish(fc_1_finish)
  );

  always #5 clk = ~clk;

  function automatic logic [1119:0] row_word(input logic [4:0] r);
    logic [1119:0] d;
    d = '0;
    for (int i = 0; i < 70; i++) d[16*i +: 16] = 16'(32 * r + i);
    return d;
  endfunction

  always @(posedge clk) begin
    if (fm_bram_ena) s1 <= row_word(fm_bram_addra);
    s2 <= s1;
  end
  assign fm_bram_douta = s2;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Caller sets fc_1_en=1 beforehand; the first edge here samples the rise.
  task automatic run_pass(input int st_r, input int st_w, input int st_n,
                          input int dr_r, input int dr_w,
                          output int lcyc, output int nwords);
    int r, w, stall, gap;
    bit seen, done, dropped;
    r = 0; w = 0; stall = 0; gap = 0;
    seen = 0; done = 0; dropped = 0;
    lcyc = -1; nwords = 0;
    out_ready = 1'b1;
    step();
    chk("issue_ena", fm_bram_ena, 1);
    chk("issue_addr", fm_bram_addra, 0);
    chk("issue_valid", out_valid, 0);
    chk("fin_clear", fc_1_finish, 0);
    for (int c = 1; c < 3000 && !done; c++) begin
      if (out_valid) begin
        if (!seen) chk("first_cyc", c, 4);
        else if (gap > 0) chk("row_gap", gap, GAP);
        gap = 0;
        seen = 1;
        chk("data", out_data, 32'(r * 32 + w));
        chk("row_last", out_row_last, (w == 24));
        chk("last", out_last, (r == 15 && w == 24));
`ifndef FM_PREFETCH_EN
        chk("ena_in_stream", fm_bram_ena, 0);
`endif
        if (r == dr_r && w == dr_w) begin
          fc_1_en = 1'b0;
          step();
          chk("abort_valid", out_valid, 0);
          chk("abort_fin", fc_1_finish, 0);
          chk("abort_ena", fm_bram_ena, 0);
          done = 1;
          dropped = 1;
        end else begin
          out_ready = !(r == st_r && w == st_w && stall < st_n);
          if (!out_ready) begin
            stall++;
          end else begin
            nwords++;
            if (r == 15 && w == 24) begin
              lcyc = c;
              done = 1;
            end else if (w == 24) begin
              w = 0;
              r++;
            end else begin
              w++;
            end
          end
        end
      end else begin
        if (seen) gap++;
`ifndef FM_PREFETCH_EN
        if (seen && gap == 1) begin
          chk("row_issue_ena", fm_bram_ena, 1);
          chk("row_issue_addr", fm_bram_addra, r);
        end
`endif
        out_ready = 1'b1;
      end
      if (!dropped) step();
    end
    chk("pass_end", done, 1);
    if (done && !dropped) begin
      chk("fin_set", fc_1_finish, 1);
      chk("done_valid", out_valid, 0);
    end
    out_ready = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    fc_1_en = 1'b0;
    out_ready = 1'b1;
    #12;
    chk("rst_ena", fm_bram_ena, 0);
    chk("rst_addr", fm_bram_addra, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_row_last", out_row_last, 0);
    chk("rst_last", out_last, 0);
    chk("rst_fin", fc_1_finish, 0);
    @(negedge clk);
    rst = 1'b0;
    step();
    step();

    fc_1_en = 1'b1;
    run_pass(-1, -1, 0, -1, -1, lc, nw);
    chk("p1_last_cyc", lc, LAST_CYC);
    chk("p1_words", nw, 400);

    fc_1_en = 1'b0;
    step();
    chk("done_hold_fin", fc_1_finish, 1);
    fc_1_en = 1'b1;
    run_pass(-1, -1, 0, -1, -1, lc, nw);
    chk("p2_last_cyc", lc, LAST_CYC);
    chk("p2_words", nw, 400);

    fc_1_en = 1'b0;
    step();
    fc_1_en = 1'b1;
    run_pass(3, 7, 5, -1, -1, lc, nw);
    chk("stall_last_cyc", lc, LAST_CYC + 5);
    chk("stall_words", nw, 400);

    fc_1_en = 1'b0;
    step();
    fc_1_en = 1'b1;
    run_pass(-1, -1, 0, 5, 10, lc, nw);
    chk("drop_words", nw, 5 * 25 + 10);
    step();
    chk("idle_valid", out_valid, 0);
    fc_1_en = 1'b1;
    run_pass(-1, -1, 0, -1, -1, lc, nw);
    chk("restart_last_cyc", lc, LAST_CYC);
    chk("restart_words", nw, 400);

    fc_1_en = 1'b0;
    step();
    fc_1_en = 1'b1;
    for (int i = 0; i < 40; i++) step();
    chk("pre_rst_valid", out_valid, 1);
    chk("pre_rst_addr", fm_bram_addra, GAP > 0 ? 1 : 2);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_data", out_data, 0);
    chk("arst_ena", fm_bram_ena, 0);
    chk("arst_addr", fm_bram_addra, 0);
    chk("arst_row_last", out_row_last, 0);
    chk("arst_last", out_last, 0);
    chk("arst_fin", fc_1_finish, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("held_en_valid", out_valid, 0);
      chk("held_en_ena", fm_bram_ena, 0);
    end
    fc_1_en = 1'b0;
    step();
    fc_1_en = 1'b1;
    run_pass(-1, -1, 0, -1, -1, lc, nw);
    chk("post_rst_last_cyc", lc, LAST_CYC);
    chk("post_rst_words", nw, 400);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
